// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: one 16-bit write frame {1,addr,data} per start.
// Ports: clk, rst_n, start, addr, data -> busy, done, sclk, copi, ncs.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be 2..255");
  end

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        ncs_q, ncs_d;
  logic        last;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    copi_d  = copi_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          sh_d    = {1'b1, addr, data};
          bit_d   = 4'd15;
          copi_d  = 1'b1;
        end
      end
      SETUP: begin
        if (last) state_d = HIGH;
      end
      HIGH: begin
        if (last) begin
          state_d = LOW;
          sh_d    = {sh_q[14:0], 1'b0};
          copi_d  = (bit_q == 4'd0) ? 1'b0 : sh_q[14];
        end
      end
      LOW: begin
        if (last) begin
          if (bit_q == 4'd0) begin
            state_d = GAP;
          end else begin
            state_d = HIGH;
            bit_d   = bit_q - 4'd1;
          end
        end
      end
      GAP: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // phase counter restarts on every state change
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // pins are registered copies of the next state's values
    ncs_d  = (state_d == IDLE) || (state_d == GAP);
    sclk_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == GAP) && (state_q != GAP);
    if (ncs_d) copi_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      sh_q    <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ncs_q   <= ncs_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign copi = copi_q;
  assign ncs  = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller at CLK_DIV 4, 2 and 255.
// Ports: none; drives three DUT instances sharing clk/rst_n/addr/data.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] addr;
  logic [7:0] data;
  logic [2:0] st;
  logic [2:0] b, d, sc, co, nc;
  logic [1:0] sel;
  logic       o_busy, o_done, o_sclk, o_copi, o_ncs;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .addr(addr), .data(data),
    .busy(b[0]), .done(d[0]), .sclk(sc[0]),
    .copi(co[0]), .ncs(nc[0])
  );

  spi_controller #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .addr(addr), .data(data),
    .busy(b[1]), .done(d[1]), .sclk(sc[1]),
    .copi(co[1]), .ncs(nc[1])
  );

  spi_controller #(.CLK_DIV(255)) u_d255 (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
    .addr(addr), .data(data),
    .busy(b[2]), .done(d[2]), .sclk(sc[2]),
    .copi(co[2]), .ncs(nc[2])
  );

  always_comb begin
    o_busy = b[sel];
    o_done = d[sel];
    o_sclk = sc[sel];
    o_copi = co[sel];
    o_ncs  = nc[sel];
  end

  int npass = 0;
  int ntot  = 0;
  int nlow, nfirst, nlast, rises, frise;
  int dcnt, dcyc, bfall, cbad, nfalls, fall2;
  logic [31:0] bits;

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, got, got, exp, exp);
  endtask

  task automatic kick(input bit hold);
    @(negedge clk);
    st[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) st[sel] = 1'b0;
  endtask

  // sample cycle c on the negedge before edge c; cycle 1 follows edge 0
  task automatic observe(input int ncyc, input int rel_at,
                         input int p1, input int p2, input int chg_at);
    logic ps, pn, pc, pb;
    nlow = 0; nfirst = -1; nlast = -1; rises = 0; frise = -1;
    dcnt = 0; dcyc = -1; bfall = -1; cbad = 0; nfalls = 0;
    fall2 = -1; bits = '0;
    ps = 1'b0; pn = 1'b1; pc = 1'b0; pb = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (!o_ncs) begin
        nlow++;
        if (nfirst < 0) nfirst = c;
        nlast = c;
      end
      if (!o_ncs && pn) begin
        nfalls++;
        if (nfalls == 2) fall2 = c;
      end
      if (o_sclk && !ps && !o_ncs) begin
        rises++;
        bits = {bits[30:0], o_copi};
        if (frise < 0) frise = c;
      end
      if (o_sclk && o_copi != pc) cbad++;
      if (o_done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
      if (!o_busy && pb && bfall < 0) bfall = c;
      ps = o_sclk; pn = o_ncs; pc = o_copi; pb = o_busy;
      if (c == p1 + 1 || c == p2 + 1) st[sel] = 1'b0;
      if (c == p1 || c == p2) st[sel] = 1'b1;
      if (c == rel_at) st[sel] = 1'b0;
      if (c == chg_at) begin
        addr = 7'h7F;
        data = 8'hFF;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st    = '0;
    sel   = 2'd0;
    addr  = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", int'(o_ncs), 1);
    chk("rst_sclk", int'(o_sclk), 0);
    chk("rst_copi", int'(o_copi), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single write, D=4
    addr = 7'h00; data = 8'hF0;
    kick(1'b0);
    observe(140, -1, -1, -1, -1);
    chk("t1_bits", int'(bits[15:0]), 32'h80F0);
    chk("t1_rises", rises, 16);
    chk("t1_frise", frise, 5);
    chk("t1_ncs_first", nfirst, 1);
    chk("t1_ncs_last", nlast, 132);
    chk("t1_ncs_cnt", nlow, 132);
    chk("t1_done_cnt", dcnt, 1);
    chk("t1_done_cyc", dcyc, 133);
    chk("t1_busy_fall", bfall, 137);
    chk("t1_copi_hi", cbad, 0);
    repeat (5) @(negedge clk);

    // back-to-back with start held
    addr = 7'h04; data = 8'h5A;
    kick(1'b1);
    observe(280, 200, -1, -1, -1);
    chk("t2_bits", int'(bits), 32'h845A845A);
    chk("t2_rises", rises, 32);
    chk("t2_falls", nfalls, 2);
    chk("t2_fall2", fall2, 138);
    chk("t2_ncs_cnt", nlow, 264);
    chk("t2_done_cnt", dcnt, 2);
    chk("t2_busy_fall", bfall, 137);
    repeat (5) @(negedge clk);

    // start pulses and input changes mid-frame are ignored
    addr = 7'h12; data = 8'h3C;
    kick(1'b0);
    observe(150, -1, 10, 100, 50);
    chk("t3_bits", int'(bits[15:0]), 32'h923C);
    chk("t3_rises", rises, 16);
    chk("t3_falls", nfalls, 1);
    chk("t3_done_cnt", dcnt, 1);
    chk("t3_busy_fall", bfall, 137);
    repeat (5) @(negedge clk);

    // asynchronous reset mid-frame
    addr = 7'h7F; data = 8'hFF;
    kick(1'b0);
    observe(60, -1, -1, -1, -1);
    chk("t4_pre_ncs", int'(o_ncs), 0);
    chk("t4_pre_copi", int'(o_copi), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ncs", int'(o_ncs), 1);
    chk("t4_sclk", int'(o_sclk), 0);
    chk("t4_copi", int'(o_copi), 0);
    chk("t4_busy", int'(o_busy), 0);
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_done) dcnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done) dcnt++;
    end
    chk("t4_no_done", dcnt, 0);
    addr = 7'h33; data = 8'hC3;
    kick(1'b0);
    observe(140, -1, -1, -1, -1);
    chk("t4_bits", int'(bits[15:0]), 32'hB3C3);
    chk("t4_rises", rises, 16);
    chk("t4_done_cyc", dcyc, 133);
    chk("t4_done_cnt", dcnt, 1);
    repeat (5) @(negedge clk);

    // minimum divider
    sel  = 2'd1;
    addr = 7'h55; data = 8'hAA;
    kick(1'b0);
    observe(75, -1, -1, -1, -1);
    chk("d2_bits", int'(bits[15:0]), 32'hD5AA);
    chk("d2_rises", rises, 16);
    chk("d2_frise", frise, 3);
    chk("d2_ncs_cnt", nlow, 66);
    chk("d2_ncs_last", nlast, 66);
    chk("d2_done_cyc", dcyc, 67);
    chk("d2_busy_fall", bfall, 69);
    chk("d2_copi_hi", cbad, 0);
    repeat (5) @(negedge clk);

    // maximum divider
    sel  = 2'd2;
    addr = 7'h2A; data = 8'h81;
    kick(1'b0);
    observe(8680, -1, -1, -1, -1);
    chk("d255_bits", int'(bits[15:0]), 32'hAA81);
    chk("d255_rises", rises, 16);
    chk("d255_frise", frise, 256);
    chk("d255_ncs_cnt", nlow, 8415);
    chk("d255_done_cyc", dcyc, 8416);
    chk("d255_busy_fall", bfall, 8671);
    chk("d255_copi_hi", cbad, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

Mode-0 SPI controller that serialises one 16-bit register-write frame per request onto the chip's SCLK/COPI/nCS lines. It is the initiator end of the register-write bus. It drives the design's SPI register peripheral in loopback benches, and any off-chip SPI target that uses the same frame format. The host side is a single-cycle start pulse with busy/done status.

## Interface
- CLK_DIV, 4: system-clock cycles per SCLK half-period. Legal range is 2..255; an illegal value fails elaboration.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  transfer request; sampled only while busy=0.
- addr  input  7  register address; latched when start is accepted.
- data  input  8  write data; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted until the end of the inter-frame gap.
- done  output  1  one-cycle pulse when nCS returns high at frame end.
- sclk  output  1  SPI clock, idle low (mode 0).
- copi  output  1  serial data, MSB first; changes only while sclk is low.
- ncs  output  1  chip select, active low.

## Operation
- Frame is 16 bits, sent bit 15 first: {1'b1 (write), addr[6:0], data[7:0]}. The frame is latched into a shift register at acceptance, so addr and data may change afterwards without effect.
- All outputs (sclk, copi, ncs, busy, done) come directly from flops, giving glitch-free pins.
- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, state IDLE. Assertion of rst_n forces these asynchronously at any point, including mid-frame. A truncated frame produces no done pulse.
- State machine:
  - IDLE: outputs at idle values. start=1 moves to SETUP.
  - SETUP: ncs=0, sclk=0, copi=bit15; lasts CLK_DIV cycles, then goes to HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles, then goes to LOW.
  - LOW: sclk=0 for CLK_DIV cycles.
    - On entry, copi takes the next bit, or 0 after bit 0 has been sent.
    - After the low phase that follows bit 0's high phase, go to GAP. Otherwise go back to HIGH.
  - GAP: ncs=1, sclk=0, copi=0, busy=1; lasts CLK_DIV cycles. done=1 in the first GAP cycle only. Then goes to IDLE with busy=0.
- Counters:
  - Phase counter: 8 bits; counts 0..CLK_DIV-1 and is reloaded on every state change.
  - Bit counter: 4 bits; counts 15 down to 0 and does not wrap.
- start while busy=1 is ignored. There is no queue or error flag.
- start held high continuously produces back-to-back frames separated by exactly the GAP.

## Timing
- Numbering: cycle 0 is the clk edge that samples start=1 with busy=0. Cycle n means the value after the n-th following edge.
- Cycle 1: ncs=0, busy=1, copi=1 (bit 15).
- Bit k (k = 15..0, i = 15-k):
  - sclk rises at cycle 1+CLK_DIV+2·i·CLK_DIV.
  - sclk falls at cycle 1+2·CLK_DIV+2·i·CLK_DIV.
- copi is stable for CLK_DIV cycles before each sclk rise and throughout the high phase.
- ncs is low for 33·CLK_DIV cycles, i.e. cycles 1..33·CLK_DIV. There are exactly 16 sclk rising edges while ncs=0.
- Cycle 33·CLK_DIV+1: ncs=1 and done=1.
- Cycle 34·CLK_DIV+1: busy=0; start is acceptable on this edge.
- With CLK_DIV=4:
  - ncs is low for cycles 1..132.
  - First sclk rise is at cycle 5.
  - done is high at cycle 133.
  - busy falls at cycle 137.
  - Back-to-back period is 137 cycles.
- Minimum CLK_DIV=2 gives each SCLK phase at least 2 receiver clocks, which the peripheral's 2-flop synchronisers require when it shares clk.

## Test plan
- Single write, CLK_DIV=4, addr=0x00, data=0xF0 → bits sampled at sclk rises while ncs=0 are 1,0000000,11110000. ncs is low for cycles 1..132, done=1 only at cycle 133, and busy=0 at cycle 137.
- Back-to-back with start held high, addr=0x04, data=0x5A → second ncs fall at cycle 138. Each frame has exactly 16 sclk rises, and each frame produces one done pulse.
- start pulsed at cycles 10 and 100 during a frame → ignored. There is no second frame, and the frame contents are unchanged even if addr/data change at cycle 50.
- rst_n asserted at cycle 60 for 3 cycles → ncs=1, sclk=0, copi=0, busy=0 asynchronously, with no done pulse. A new start after release yields a complete, correct frame.
- CLK_DIV=2 and CLK_DIV=255 → ncs low for 66 and 8415 cycles respectively. No copi transition occurs while sclk=1.
- Loopback into the SPI register peripheral on the same clk: write addr=0x00 data=0xA5 → the peripheral's addressed register reads 0xA5 after nCS rises. A frame with an out-of-range address leaves all peripheral registers unchanged.
